// File: rtl/uart_phy.sv
// Full-duplex UART transceiver: configurable baud, data width, parity and stop bits.
// RX uses a 2-FF synchroniser, 3-sample majority vote per bit and false-start rejection.
module uart_phy #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 srx,
    output logic                 stx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 err_clr
);

    localparam int CPB = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(CPB * STOP_BITS);
    localparam int IW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] STOP_END = CW'(CPB * STOP_BITS - 1);
    localparam logic [CW-1:0] SMP0     = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] SMP1     = CW'(CPB / 2);
    localparam logic [CW-1:0] SMP2     = CW'(CPB / 2 + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY == 1);

    generate
        if (CPB < 8) begin : g_cpb_check
            $error("uart_phy: clocks per bit must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_width_check
            $error("uart_phy: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_parity_check
            $error("uart_phy: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
            $error("uart_phy: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam state_t AFTER_DATA = (PARITY != 0) ? S_PARITY : S_STOP;

    // ---------------- transmitter ----------------
    state_t                 tx_state_reg, tx_state_next;
    logic [CW-1:0]          tx_cnt_reg, tx_cnt_next;
    logic [IW-1:0]          tx_idx_reg, tx_idx_next;
    logic [DATA_BITS-1:0]   tx_shift_reg, tx_shift_next;
    logic                   tx_par_reg, tx_par_next;
    logic                   stx_reg, stx_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            stx_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_idx_reg   <= tx_idx_next;
            tx_shift_reg <= tx_shift_next;
            tx_par_reg   <= tx_par_next;
            stx_reg      <= stx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_idx_next   = tx_idx_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        stx_next      = 1'b1;
        case (tx_state_reg)
            S_IDLE: begin
                if (tx_valid) begin
                    tx_state_next = S_START;
                    tx_cnt_next   = '0;
                    tx_idx_next   = '0;
                    tx_shift_next = tx_data;
                    tx_par_next   = (^tx_data) ^ PAR_ODD;
                end
            end
            S_START: begin
                if (tx_cnt_reg == BIT_END) begin
                    tx_state_next = S_DATA;
                    tx_cnt_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_reg == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_idx_reg == LAST_BIT) begin
                        tx_state_next = AFTER_DATA;
                    end else begin
                        tx_idx_next = tx_idx_reg + 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            S_PARITY: begin
                if (tx_cnt_reg == BIT_END) begin
                    tx_state_next = S_STOP;
                    tx_cnt_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_reg == STOP_END) begin
                    tx_state_next = S_IDLE;
                    tx_cnt_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = S_IDLE;
        endcase
        // Line level follows the state being entered so stx stays a plain register.
        case (tx_state_next)
            S_START:  stx_next = 1'b0;
            S_DATA:   stx_next = tx_shift_next[0];
            S_PARITY: stx_next = tx_par_next;
            default:  stx_next = 1'b1;
        endcase
    end

    assign stx      = stx_reg;
    assign tx_ready = (tx_state_reg == S_IDLE);

    // ---------------- receiver ----------------
    logic [1:0]             sync_reg;
    logic                   rx_s;
    state_t                 rx_state_reg, rx_state_next;
    logic [CW-1:0]          rx_cnt_reg, rx_cnt_next;
    logic [IW-1:0]          rx_idx_reg, rx_idx_next;
    logic [DATA_BITS-1:0]   rx_shift_reg, rx_shift_next;
    logic [1:0]             smp_reg, smp_next;
    logic                   rx_perr_reg, rx_perr_next;
    logic                   vote;
    logic                   frame_done;
    logic [DATA_BITS-1:0]   rx_data_reg;
    logic                   rx_valid_reg, rx_ferr_reg, rx_perr_out_reg, rx_ovr_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], srx};
        end
    end

    assign rx_s = sync_reg[1];
    assign vote = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & rx_s) | (smp_reg[1] & rx_s);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_reg <= S_IDLE;
            rx_cnt_reg   <= '0;
            rx_idx_reg   <= '0;
            rx_shift_reg <= '0;
            smp_reg      <= 2'b11;
            rx_perr_reg  <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_idx_reg   <= rx_idx_next;
            rx_shift_reg <= rx_shift_next;
            smp_reg      <= smp_next;
            rx_perr_reg  <= rx_perr_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_idx_next   = rx_idx_reg;
        rx_shift_next = rx_shift_reg;
        smp_next      = smp_reg;
        rx_perr_next  = rx_perr_reg;
        frame_done    = 1'b0;
        if (rx_cnt_reg == SMP0) smp_next[0] = rx_s;
        if (rx_cnt_reg == SMP1) smp_next[1] = rx_s;
        case (rx_state_reg)
            S_IDLE: begin
                rx_cnt_next = '0;
                if (!rx_s) begin
                    // The cycle the low is first seen is count 0 of the start bit.
                    rx_state_next = S_START;
                    rx_cnt_next   = CW'(1);
                    rx_idx_next   = '0;
                    rx_perr_next  = 1'b0;
                end
            end
            S_START: begin
                if (rx_cnt_reg == SMP2 && vote) begin
                    rx_state_next = S_IDLE;
                    rx_cnt_next   = '0;
                end else if (rx_cnt_reg == BIT_END) begin
                    rx_state_next = S_DATA;
                    rx_cnt_next   = '0;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_reg == SMP2) rx_shift_next = {vote, rx_shift_reg[DATA_BITS-1:1]};
                if (rx_cnt_reg == BIT_END) begin
                    rx_cnt_next = '0;
                    if (rx_idx_reg == LAST_BIT) begin
                        rx_state_next = AFTER_DATA;
                    end else begin
                        rx_idx_next = rx_idx_reg + 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_cnt_reg == SMP2) rx_perr_next = (^rx_shift_reg) ^ vote ^ PAR_ODD;
                if (rx_cnt_reg == BIT_END) begin
                    rx_state_next = S_STOP;
                    rx_cnt_next   = '0;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_reg == SMP2) begin
                    rx_state_next = S_IDLE;
                    rx_cnt_next   = '0;
                    frame_done    = 1'b1;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    // A completed frame is dropped (and overrun flagged) only if the held one is not being taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            rx_ferr_reg     <= 1'b0;
            rx_perr_out_reg <= 1'b0;
            rx_ovr_reg      <= 1'b0;
        end else begin
            if (frame_done && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg     <= rx_shift_reg;
                rx_ferr_reg     <= ~vote;
                rx_perr_out_reg <= rx_perr_reg;
                rx_valid_reg    <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
            if (frame_done && rx_valid_reg && !rx_ready) begin
                rx_ovr_reg <= 1'b1;
            end else if (err_clr) begin
                rx_ovr_reg <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_reg;
    assign rx_valid      = rx_valid_reg;
    assign rx_frame_err  = rx_ferr_reg;
    assign rx_parity_err = rx_perr_out_reg;
    assign rx_overrun    = rx_ovr_reg;

endmodule

// File: tb/tb_uart_phy.sv
// Directed bench for uart_phy: 8N1 loopback/RX cases at 10 clocks per bit,
// parity variants, and a 7-bit/2-stop instance at the default 434 clocks per bit.
module tb_uart_phy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    // 8N1 instance, CPB = 10
    logic       srx_drv, loop_en, err_clr;
    logic       d0_srx, d0_stx, d0_tx_valid, d0_tx_ready, d0_rx_valid, d0_rx_ready;
    logic [7:0] d0_tx_data, d0_rx_data;
    logic       d0_ferr, d0_perr, d0_ovr;
    assign d0_srx = loop_en ? d0_stx : srx_drv;

    // parity instances share one line
    logic       srx_p;
    logic [7:0] zero8;
    logic       zero1, one1;
    logic       pe_stx, pe_tx_ready, pe_rx_valid, pe_ferr, pe_perr, pe_ovr;
    logic [7:0] pe_rx_data;
    logic       po_stx, po_tx_ready, po_rx_valid, po_ferr, po_perr, po_ovr;
    logic [7:0] po_rx_data;

    // default clock/baud, 7 data bits, 2 stop bits
    logic [6:0] b_tx_data, b_rx_data;
    logic       b_tx_valid, b_stx, b_tx_ready, b_rx_valid, b_ferr, b_perr, b_ovr;

    uart_phy #(.CLK_HZ(1000000), .BAUD(100000)) u_d0 (
        .clk(clk), .reset_n(reset_n), .srx(d0_srx), .stx(d0_stx),
        .tx_data(d0_tx_data), .tx_valid(d0_tx_valid), .tx_ready(d0_tx_ready),
        .rx_data(d0_rx_data), .rx_valid(d0_rx_valid), .rx_ready(d0_rx_ready),
        .rx_frame_err(d0_ferr), .rx_parity_err(d0_perr), .rx_overrun(d0_ovr),
        .err_clr(err_clr)
    );

    uart_phy #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(2)) u_pe (
        .clk(clk), .reset_n(reset_n), .srx(srx_p), .stx(pe_stx),
        .tx_data(zero8), .tx_valid(zero1), .tx_ready(pe_tx_ready),
        .rx_data(pe_rx_data), .rx_valid(pe_rx_valid), .rx_ready(zero1),
        .rx_frame_err(pe_ferr), .rx_parity_err(pe_perr), .rx_overrun(pe_ovr),
        .err_clr(zero1)
    );

    uart_phy #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(1)) u_po (
        .clk(clk), .reset_n(reset_n), .srx(srx_p), .stx(po_stx),
        .tx_data(zero8), .tx_valid(zero1), .tx_ready(po_tx_ready),
        .rx_data(po_rx_data), .rx_valid(po_rx_valid), .rx_ready(zero1),
        .rx_frame_err(po_ferr), .rx_parity_err(po_perr), .rx_overrun(po_ovr),
        .err_clr(zero1)
    );

    uart_phy #(.DATA_BITS(7), .STOP_BITS(2)) u_big (
        .clk(clk), .reset_n(reset_n), .srx(one1), .stx(b_stx),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(zero1),
        .rx_frame_err(b_ferr), .rx_parity_err(b_perr), .rx_overrun(b_ovr),
        .err_clr(zero1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Drives one 10-clock-per-bit frame on line 0 (srx_drv) or 1 (srx_p).
    // pbit < 0 means no parity bit; glitch_cyc inverts one cycle; clr_at pulses err_clr.
    task automatic send_frame(input logic [8:0] data, input int nbits, input int pbit,
                              input logic stop_v, input int glitch_cyc, input int clr_at,
                              input int line);
        logic bits [0:11];
        int   nb;
        logic v;
        bits[0] = 1'b0;
        for (int k = 0; k < nbits; k++) bits[1+k] = data[k];
        nb = 1 + nbits;
        if (pbit >= 0) begin
            bits[nb] = pbit[0];
            nb++;
        end
        bits[nb] = stop_v;
        nb++;
        for (int i = 0; i < nb * 10; i++) begin
            v = bits[i/10];
            if (i == glitch_cyc) v = ~v;
            err_clr = (i == clr_at);
            if (line == 0) srx_drv = v;
            else           srx_p   = v;
            @(negedge clk);
        end
        err_clr = 1'b0;
        srx_drv = 1'b1;
        srx_p   = 1'b1;
    endtask

    task automatic wait_valid(input int sel, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if ((sel == 0 && d0_rx_valid) || (sel == 1 && pe_rx_valid)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic consume_d0();
        d0_rx_ready = 1'b1;
        @(negedge clk);
        d0_rx_ready = 1'b0;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] data, input logic ferr);
        bit ok;
        wait_valid(0, 300, ok);
        check_val({tag, "_seen"}, 32'(ok), 32'd1);
        check_val({tag, "_data"}, 32'(d0_rx_data), 32'(data));
        check_val({tag, "_ferr"}, 32'(d0_ferr), 32'(ferr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    logic       stx_h [1:101];
    logic       rdy_h [1:101];
    logic [9:0] exp_line;
    bit         ok;
    int         seen, bad_low, bad_high;

    initial begin
        reset_n     = 1'b0;
        srx_drv     = 1'b1;
        srx_p       = 1'b1;
        loop_en     = 1'b0;
        err_clr     = 1'b0;
        zero8       = '0;
        zero1       = 1'b0;
        one1        = 1'b1;
        d0_tx_data  = '0;
        d0_tx_valid = 1'b0;
        d0_rx_ready = 1'b0;
        b_tx_data   = '0;
        b_tx_valid  = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_stx", 32'(d0_stx), 32'd1);
        check_val("rst_tx_ready", 32'(d0_tx_ready), 32'd1);
        check_val("rst_rx_valid", 32'(d0_rx_valid), 32'd0);
        check_val("rst_rx_data", 32'(d0_rx_data), 32'd0);
        check_val("rst_flags", 32'({d0_ferr, d0_perr, d0_ovr}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. loopback 0xA5
        loop_en     = 1'b1;
        d0_tx_data  = 8'hA5;
        d0_tx_valid = 1'b1;
        @(negedge clk);
        d0_tx_valid = 1'b0;
        d0_tx_data  = 8'h00;
        for (int i = 1; i <= 101; i++) begin
            stx_h[i] = d0_stx;
            rdy_h[i] = d0_tx_ready;
            @(negedge clk);
        end
        exp_line = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++)
            check_val($sformatf("t1_stx_bit%0d", b), 32'(stx_h[10*b+5]), 32'(exp_line[b]));
        check_val("t1_stx_first_low", 32'(stx_h[1]), 32'd0);
        check_val("t1_stx_last_low", 32'(stx_h[10]), 32'd0);
        check_val("t1_stx_bit0_edge", 32'(stx_h[11]), 32'd1);
        check_val("t1_ready_at_99", 32'(rdy_h[100]), 32'd0);
        check_val("t1_ready_at_100", 32'(rdy_h[101]), 32'd1);
        expect_rx("t1_rx", 8'hA5, 1'b0);
        check_val("t1_rx_perr", 32'(d0_perr), 32'd0);
        consume_d0();
        check_val("t1_rx_valid_drop", 32'(d0_rx_valid), 32'd0);
        loop_en = 1'b0;
        repeat (5) @(negedge clk);

        // 4a. 3-cycle low pulse is a false start
        srx_drv = 1'b0;
        repeat (3) @(negedge clk);
        srx_drv = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            seen += int'(d0_rx_valid);
            @(negedge clk);
        end
        check_val("t4_false_start", 32'(seen), 32'd0);

        // 3. stop bit low, then a clean frame
        send_frame(9'h05A, 8, -1, 1'b0, -1, -1, 0);
        expect_rx("t3_bad_stop", 8'h5A, 1'b1);
        consume_d0();
        repeat (20) @(negedge clk);
        check_val("t3_no_spurious", 32'(d0_rx_valid), 32'd0);
        send_frame(9'h011, 8, -1, 1'b1, -1, -1, 0);
        expect_rx("t3_next", 8'h11, 1'b0);
        consume_d0();

        // 4b. one-cycle glitch at the centre sample of a data bit
        send_frame(9'h0FF, 8, -1, 1'b1, 45, -1, 0);
        expect_rx("t4_glitch_ones", 8'hFF, 1'b0);
        consume_d0();
        send_frame(9'h000, 8, -1, 1'b1, 25, -1, 0);
        expect_rx("t4_glitch_zeros", 8'h00, 1'b0);
        consume_d0();

        // 5. overrun
        send_frame(9'h011, 8, -1, 1'b1, -1, -1, 0);
        send_frame(9'h022, 8, -1, 1'b1, -1, -1, 0);
        check_val("t5_valid", 32'(d0_rx_valid), 32'd1);
        check_val("t5_data_kept", 32'(d0_rx_data), 32'h11);
        check_val("t5_overrun", 32'(d0_ovr), 32'd1);
        consume_d0();
        check_val("t5_valid_drop", 32'(d0_rx_valid), 32'd0);
        check_val("t5_overrun_sticky", 32'(d0_ovr), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("t5_overrun_cleared", 32'(d0_ovr), 32'd0);
        send_frame(9'h033, 8, -1, 1'b1, -1, -1, 0);
        check_val("t5_third_load", 32'(d0_rx_data), 32'h33);
        send_frame(9'h044, 8, -1, 1'b1, -1, 98, 0);
        check_val("t5_set_beats_clear", 32'(d0_ovr), 32'd1);
        check_val("t5_third_kept", 32'(d0_rx_data), 32'h33);
        consume_d0();

        // 2. parity: 0x03 with parity bit 1 (wrong for even, right for odd)
        send_frame(9'h003, 8, 1, 1'b1, -1, -1, 1);
        wait_valid(1, 50, ok);
        check_val("t2_even_seen", 32'(ok), 32'd1);
        check_val("t2_even_data", 32'(pe_rx_data), 32'h03);
        check_val("t2_even_perr", 32'(pe_perr), 32'd1);
        check_val("t2_even_ferr", 32'(pe_ferr), 32'd0);
        check_val("t2_odd_valid", 32'(po_rx_valid), 32'd1);
        check_val("t2_odd_data", 32'(po_rx_data), 32'h03);
        check_val("t2_odd_perr", 32'(po_perr), 32'd0);

        // 6. CPB 434, 7 data bits, 2 stop bits: 0x7F
        b_tx_data  = 7'h7F;
        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        bad_low  = 0;
        bad_high = 0;
        for (int i = 1; i <= 4341; i++) begin
            if (i <= 434)       bad_low  += int'(b_stx !== 1'b0);
            else if (i <= 4340) bad_high += int'(b_stx !== 1'b1);
            if (i == 4340) check_val("t6_ready_busy_end", 32'(b_tx_ready), 32'd0);
            if (i == 4341) check_val("t6_ready_return", 32'(b_tx_ready), 32'd1);
            @(negedge clk);
        end
        check_val("t6_low_434", 32'(bad_low), 32'd0);
        check_val("t6_high_9x434", 32'(bad_high), 32'd0);

        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        repeat (200) @(negedge clk);
        check_val("t6_mid_stx", 32'(b_stx), 32'd0);
        check_val("t6_mid_ready", 32'(b_tx_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_async_stx", 32'(b_stx), 32'd1);
        check_val("t6_async_ready", 32'(b_tx_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("t6_post_reset_stx", 32'(b_stx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
